// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding,
// header nibble and header-byte helper.
// The HDR state exists only when UART_TX_SCHED_HDR_EN is defined.
package uart_tx_sched_pkg;

   // Upper nibble of the per-packet header byte
   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
`ifdef UART_TX_SCHED_HDR_EN
      HDR       = 3'd1,
`endif
      LOAD      = 3'd2,
      TRIG      = 3'd3,
      WAIT_BUSY = 3'd4,
      WAIT_DONE = 3'd5
   } state_t;

   // Header byte announcing which requester owns the following packet
   function automatic logic [7:0] hdr_byte(input logic [2:0] id);
      return {HDR_NIBBLE, 1'b0, id};
   endfunction

endpackage

// File: rtl/uart_rr_arb.sv
// Round-robin arbiter: searches the request vector starting one past the
// pointer (the previous winner) and wraps from NUM_REQ-1 back to 0.
// Purely combinational; the caller registers the result.
module uart_rr_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid
);

   // First requester found at ptr+1, ptr+2, ... (mod NUM_REQ) wins
   always_comb begin
      logic [ID_W:0] cand;
      cand      = '0;
      gnt       = '0;
      gnt_id    = '0;
      gnt_valid = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         // ptr + i never exceeds 2*NUM_REQ-1, so one subtraction is a full modulo
         cand = {1'b0, ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!gnt_valid && req[cand[ID_W-1:0]]) begin
            gnt_valid               = 1'b1;
            gnt_id                  = cand[ID_W-1:0];
            gnt[cand[ID_W-1:0]]     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: arbitrates NUM_REQ byte streams round-robin,
// holds a grant for a whole packet and feeds bytes one at a time to a UART
// transmitter through a trigger / idle handshake.
// Optional build macro UART_TX_SCHED_HDR_EN: prefix each packet with a
// header byte {4'hA, 1'b0, grant[2:0]}.
module uart_tx_sched #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [NUM_REQ*8-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic                 o_tx_trig,
   output logic [7:0]           o_tx_data,
   input  logic                 i_tx_idle,
   output logic [ID_W-1:0]      o_grant_id,
   output logic                 o_busy
);

   import uart_tx_sched_pkg::*;

   state_t              state;
   logic [NUM_REQ-1:0]  grant_oh;
   logic [ID_W-1:0]     last_grant;
   logic                last_cap;

   logic [NUM_REQ-1:0]  arb_gnt;
   logic [ID_W-1:0]     arb_id;
   logic                arb_valid;

   logic                sel_valid;
   logic [7:0]          sel_data;
   logic                sel_last;

   uart_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req       (i_req_valid),
      .ptr       (last_grant),
      .gnt       (arb_gnt),
      .gnt_id    (arb_id),
      .gnt_valid (arb_valid)
   );

   // Byte lane of the requester that currently owns the link
   assign sel_valid = |(grant_oh & i_req_valid);
   assign sel_data  = i_req_data[{o_grant_id, 3'b000} +: 8];
   assign sel_last  = i_req_last[o_grant_id];

   // Ready follows the granted valid in LOAD so a stalled requester costs
   // nothing; trigger is gated by idle so a running frame is never restarted
   assign o_req_ready = (state == LOAD) ? (grant_oh & i_req_valid) : '0;
   assign o_tx_trig   = (state == TRIG) && i_tx_idle;
   assign o_busy      = (state != IDLE);

   // Packet sequencing: grant, fetch byte, trigger, wait out the frame
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         grant_oh   <= '0;
         o_grant_id <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
         o_tx_data  <= 8'h00;
         last_cap   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  grant_oh   <= arb_gnt;
                  o_grant_id <= arb_id;
`ifdef UART_TX_SCHED_HDR_EN
                  state      <= HDR;
`else
                  state      <= LOAD;
`endif
               end
            end
`ifdef UART_TX_SCHED_HDR_EN
            HDR: begin
               // Header is never the end of a packet, so the payload follows
               o_tx_data <= hdr_byte(3'(o_grant_id));
               last_cap  <= 1'b0;
               state     <= TRIG;
            end
`endif
            LOAD: begin
               // A stalled requester keeps the grant; no filler is sent
               if (sel_valid) begin
                  o_tx_data <= sel_data;
                  last_cap  <= sel_last;
                  state     <= TRIG;
               end
            end
            TRIG: begin
               if (i_tx_idle) begin
                  state <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (!i_tx_idle) begin
                  state <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (i_tx_idle) begin
                  if (last_cap) begin
                     last_grant <= o_grant_id;
                     state      <= IDLE;
                  end else begin
                     state      <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte-stream requesters; legal range 2..8.
REQ-002 Parameter ID_W, default $clog2(NUM_REQ), width of the requester index.
REQ-003 clk  input  1  system clock.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 i_req_data  input  NUM_REQ*8  per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 i_req_last  input  NUM_REQ  per-requester end-of-packet marker, qualified by valid.
REQ-008 o_req_ready  output  NUM_REQ  per-requester byte accept; at most one bit high.
REQ-009 o_tx_trig  output  1  single-cycle start pulse to the UART transmitter.
REQ-010 o_tx_data  output  8  byte to the transmitter, stable from trig until the frame completes.
REQ-011 i_tx_idle  input  1  transmitter idle flag; drops one cycle after trig and rises when the frame ends.
REQ-012 o_grant_id  output  ID_W  index of the requester owning the link.
REQ-013 o_busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, HDR, LOAD, TRIG, WAIT_BUSY and WAIT_DONE.
REQ-015 In IDLE with any valid high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ, and SHALL latch o_grant_id.
REQ-016 A grant SHALL be held for a whole packet, up to and including the byte with last=1; no preemption.
REQ-017 In LOAD, o_req_ready[grant] SHALL be high combinationally only while i_req_valid[grant] is high; the byte and last SHALL be captured on that cycle, then the FSM SHALL go to TRIG.
REQ-018 If the granted valid drops mid-packet, the block SHALL stay in LOAD, keep the grant, and never emit a filler byte.
REQ-019 TRIG SHALL assert o_tx_trig for exactly one cycle, and only when i_tx_idle=1; otherwise it SHALL wait in TRIG.
REQ-020 WAIT_BUSY SHALL wait for i_tx_idle=0, then go to WAIT_DONE.
REQ-021 WAIT_DONE SHALL wait for i_tx_idle=1, then go to IDLE if the captured last=1 (updating last_grant), else to LOAD.
REQ-022 o_tx_trig SHALL never be asserted while i_tx_idle=0 or outside TRIG; a retrigger would corrupt a frame.
REQ-023 Latency SHALL be: valid seen in IDLE at cycle 0 -> ready at cycle 1 -> trig at cycle 2, given the transmitter is idle.
REQ-024 With a single active requester, the block SHALL re-grant that requester back-to-back with no extra idle cycle beyond IDLE.
REQ-025 The round-robin pointer SHALL wrap from NUM_REQ-1 to 0.

Reset
REQ-026 Reset SHALL set: state IDLE, o_req_ready 0, o_tx_trig 0, o_tx_data 0x00, o_grant_id 0, o_busy 0, last_grant NUM_REQ-1 so that requester 0 wins first.
REQ-027 Reset mid-packet SHALL abandon the packet; the requester re-arbitrates after reset.

Configuration
REQ-028 When macro UART_TX_SCHED_HDR_EN is defined, each packet SHALL begin with HDR, which sends the header byte {4'hA, 1'b0, grant[2:0]} through TRIG, WAIT_BUSY and WAIT_DONE before LOAD, with no ready asserted during the header.
REQ-029 When UART_TX_SCHED_HDR_EN is undefined, the HDR state and its logic SHALL be absent, and IDLE SHALL go directly to LOAD.

Structure
REQ-030 Package uart_tx_sched_pkg SHALL hold the state enum typedef and the header nibble constant 4'hA.
REQ-031 The round-robin grant logic SHALL be sub-module uart_rr_arb (request vector, pointer in, one-hot grant and index out).

Verification
REQ-032 A bench SHALL cover each of the following scenarios:
- Requester 0 sends a 1-byte packet 0x55 with last=1 -> exactly one trig, o_tx_data=0x55, return to IDLE, o_busy low.
- Requesters 0..3 each request a 2-byte packet together -> packets are served in order 0,1,2,3 and bytes are never interleaved.
- Requester 2 drops valid for 10 cycles mid-packet -> the grant is held, no trig occurs, and transmission resumes on the next valid.
- i_tx_idle is held low for 20 cycles at TRIG entry -> no trig pulse until idle=1.
- With HDR_EN, requester 3 sends 0x12 -> the line sends 0xA3 then 0x12.
- Reset is asserted during WAIT_DONE -> all outputs take their reset values immediately and the next grant goes to requester 0.
